// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - byte-wide instruction fetch sequencer with loader arbitration; optional PREFETCH_EN
module instr_fetch_ctrl #(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [31:0]   PC,
    output logic [31:0]   INSTRUCTION,
    output logic          BUSYWAIT,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [7:0]    MEM_WDATA,
    input  logic [7:0]    MEM_RDATA,
    input  logic          MEM_ACK,
    input  logic          LD_REQ,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [7:0]    LD_WDATA,
    output logic          LD_GNT
);
    localparam int TW = AW - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LOAD   = 2'd2
`ifdef PREFETCH_EN
        ,
        PFETCH = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q;
    logic          valid_q;
    logic [TW-1:0] tag_q;
    logic [TW-1:0] faddr_q;
    logic [1:0]    cnt_q;
    logic [TW-1:0] pc_word;
    logic          hit;
    logic          last_ack;
    logic          unused_pc;

    assign pc_word     = PC[AW-1:2];
    assign hit         = valid_q && (tag_q == pc_word);
    assign last_ack    = MEM_ACK && (cnt_q == 2'd3);
    assign INSTRUCTION = instr_q;
    assign BUSYWAIT    = RESET_N && !hit;
    assign unused_pc   = &{1'b0, PC[31:AW], PC[1:0]};

`ifdef PREFETCH_EN
    logic          pf_valid_q;
    logic [TW-1:0] pf_tag_q;
    logic [31:0]   pf_data_q;
    logic [TW-1:0] next_tag;
    logic          pf_swap;
    logic          pf_want;

    assign next_tag = tag_q + TW'(1);
    assign pf_swap  = !hit && pf_valid_q && (pf_tag_q == pc_word);
    assign pf_want  = hit && !(pf_valid_q && (pf_tag_q == next_tag));
`endif

    // State register; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and memory strobes; loader wins over a pending miss in IDLE.
    always_comb begin
        state_d   = state_q;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = 8'h00;
        LD_GNT    = 1'b0;
        case (state_q)
            IDLE: begin
                if (LD_REQ)       state_d = LOAD;
`ifdef PREFETCH_EN
                else if (pf_swap) state_d = IDLE;
                else if (!hit)    state_d = FETCH;
                else if (pf_want) state_d = PFETCH;
`else
                else if (!hit)    state_d = FETCH;
`endif
            end
            FETCH: begin
                MEM_READ = 1'b1;
                MEM_ADDR = {faddr_q, cnt_q};
                if (last_ack) state_d = IDLE;
            end
`ifdef PREFETCH_EN
            PFETCH: begin
                MEM_READ = 1'b1;
                MEM_ADDR = {faddr_q, cnt_q};
                if (last_ack) state_d = IDLE;
            end
`endif
            LOAD: begin
                MEM_WRITE = 1'b1;
                MEM_ADDR  = LD_ADDR;
                MEM_WDATA = LD_WDATA;
                if (MEM_ACK) begin
                    LD_GNT  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer datapath: byte assembly, tag/valid bookkeeping and loader invalidation.
    // The buffer is marked invalid when a fetch starts so a partially overwritten
    // word can never be reported as a hit if PC returns to the old tag mid-fetch.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            faddr_q    <= '0;
            cnt_q      <= 2'd0;
`ifdef PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= 32'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 2'd0;
                    if (state_d == FETCH) begin
                        faddr_q <= pc_word;
                        valid_q <= 1'b0;
                    end
`ifdef PREFETCH_EN
                    if (state_d == PFETCH) begin
                        faddr_q    <= next_tag;
                        pf_valid_q <= 1'b0;
                    end
                    if (!LD_REQ && pf_swap) begin
                        instr_q    <= pf_data_q;
                        tag_q      <= pf_tag_q;
                        valid_q    <= 1'b1;
                        pf_valid_q <= 1'b0;
                    end
`endif
                end
                FETCH: begin
                    if (MEM_ACK) begin
                        instr_q[{cnt_q, 3'b000} +: 8] <= MEM_RDATA;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            tag_q   <= faddr_q;
                            valid_q <= 1'b1;
                        end
                    end
                end
`ifdef PREFETCH_EN
                PFETCH: begin
                    if (MEM_ACK) begin
                        pf_data_q[{cnt_q, 3'b000} +: 8] <= MEM_RDATA;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            pf_tag_q   <= faddr_q;
                            pf_valid_q <= 1'b1;
                        end
                    end
                end
`endif
                LOAD: begin
                    if (MEM_ACK) begin
                        if (LD_ADDR[AW-1:2] == tag_q) valid_q <= 1'b0;
`ifdef PREFETCH_EN
                        if (LD_ADDR[AW-1:2] == pf_tag_q) pf_valid_q <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
